// File: rtl/seq_multiply_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_multiply_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_sign_adj.sv
// Sign handling around the unsigned core: operand magnitudes in, conditional negate out.
// Combinational, zero latency; no flow control (pure function of inputs).
// Used only when SEQ_MULT_SIGNED_EN is defined.
module mult_sign_adj #(
    parameter int WIDTH = 4
) (
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 neg,
    input  logic [2*WIDTH-1:0]   acc,
    output logic [WIDTH-1:0]     a_mag,
    output logic [WIDTH-1:0]     b_mag,
    output logic                 prod_neg,
    output logic [2*WIDTH-1:0]   res
);

    // The most-negative value negates to itself, which read unsigned is its magnitude.
    always_comb begin
        a_mag    = (sgn && a[WIDTH-1]) ? -a : a;
        b_mag    = (sgn && b[WIDTH-1]) ? -b : b;
        prod_neg = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        res      = neg ? -acc : acc;
    end

endmodule

// File: rtl/seq_multiply.sv
// Radix-2 shift-add multiplier, one partial product per clock (signed mode: SEQ_MULT_SIGNED_EN).
// Latency exactly WIDTH cycles from accepted start to the done pulse.
// No backpressure: start is ignored while busy; a start in the done cycle is accepted.
module seq_multiply
    import seq_multiply_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 sgn,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int CW = cnt_w(WIDTH);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   out_q, out_d;

    logic [2*WIDTH-1:0]   acc_nx;
    logic [2*WIDTH-1:0]   res_fin;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q, neg_d;
    logic prod_neg;

    mult_sign_adj #(.WIDTH(WIDTH)) u_sign_adj (
        .sgn      (sgn),
        .a        (a),
        .b        (b),
        .neg      (neg_q),
        .acc      (acc_nx),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .prod_neg (prod_neg),
        .res      (res_fin)
    );
`else
    assign a_mag   = a;
    assign b_mag   = b;
    assign res_fin = acc_nx;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        out_d    = out_q;
`ifdef SEQ_MULT_SIGNED_EN
        neg_d    = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    cnt_d    = '0;
`ifdef SEQ_MULT_SIGNED_EN
                    neg_d    = prod_neg;
`endif
                end
            end
            RUN: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Final iteration: publish the sum including this cycle's partial product.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    out_d   = res_fin;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            out_q    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            out_q    <= out_d;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_seq_multiply.sv
// Self-checking bench for seq_multiply at WIDTH=4 and WIDTH=8 (signed vectors with SEQ_MULT_SIGNED_EN).
module tb_seq_multiply;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4;
    logic [7:0] out4;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] out8;

`ifdef SEQ_MULT_SIGNED_EN
    logic sgn4 = 1'b0;
    logic sgn8 = 1'b0;
`endif

    seq_multiply #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
`ifdef SEQ_MULT_SIGNED_EN
        .sgn   (sgn4),
`endif
        .busy  (busy4),
        .done  (done4),
        .out   (out4)
    );

    seq_multiply #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
`ifdef SEQ_MULT_SIGNED_EN
        .sgn   (sgn8),
`endif
        .busy  (busy8),
        .done  (done8),
        .out   (out8)
    );

    typedef struct {
        logic [63:0] exp;
        int          cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sgn;
        logic [7:0] exp;
    } vec4_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitors: pop the scoreboard on each done pulse and check value and latency.
    logic prev_done4 = 1'b0;
    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                check("w4_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("w4_out", longint'(out4), longint'(e.exp));
                check("w4_latency", longint'(cyc - e.cyc), 4);
            end
            if (prev_done4) check("w4_done_single_cycle", 1, 0);
        end
        prev_done4 = done4;
    end

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                check("w8_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("w8_out", longint'(out8), longint'(e.exp));
                check("w8_latency", longint'(cyc - e.cyc), 8);
            end
        end
    end

    task automatic wait_idle4();
        int n = 0;
        while (busy4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy4) check("w4_idle_timeout", 1, 0);
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (busy8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy8) check("w8_idle_timeout", 1, 0);
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [7:0] exp);
        exp_t e;
        wait_idle4();
        a4 = a;
        b4 = b;
`ifdef SEQ_MULT_SIGNED_EN
        sgn4 = s;
`else
        if (s) check("w4_signed_vector_in_unsigned_build", 1, 0);
`endif
        start4 = 1'b1;
        e.exp = 64'(exp);
        e.cyc = cyc + 1;
        q4.push_back(e);
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'hx;
        b4 = 4'hx;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        exp_t e;
        wait_idle8();
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        e.exp = 64'(exp);
        e.cyc = cyc + 1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'hx;
        b8 = 8'hx;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q4.size() != 0) check("w4_drain_timeout", longint'(q4.size()), 0);
        if (q8.size() != 0) check("w8_drain_timeout", longint'(q8.size()), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec4_t vecs[$];
        vecs.push_back('{4'd15, 4'd15, 1'b0, 8'd225});
        vecs.push_back('{4'd10, 4'd10, 1'b0, 8'd100});
        vecs.push_back('{4'd9,  4'd8,  1'b0, 8'd72});
        vecs.push_back('{4'd0,  4'd7,  1'b0, 8'd0});
        vecs.push_back('{4'd7,  4'd1,  1'b0, 8'd7});
        vecs.push_back('{4'hD,  4'd5,  1'b0, 8'd65});
        vecs.push_back('{4'd8,  4'd2,  1'b0, 8'd16});
`ifdef SEQ_MULT_SIGNED_EN
        vecs.push_back('{4'h8,  4'h8,  1'b1, 8'h40});
        vecs.push_back('{4'hD,  4'd5,  1'b1, 8'hF1});
        vecs.push_back('{4'd7,  4'h9,  1'b1, 8'hCF});
        vecs.push_back('{4'hF,  4'hF,  1'b1, 8'h01});
        vecs.push_back('{4'hD,  4'd0,  1'b1, 8'h00});
`endif

        // Reset state
        #12;
        check("rst_busy4", longint'(busy4), 0);
        check("rst_done4", longint'(done4), 0);
        check("rst_out4",  longint'(out4), 0);
        check("rst_busy8", longint'(busy8), 0);
        check("rst_out8",  longint'(out8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 15*15: busy for exactly 4 cycles, done after the 4th edge, out holds
        issue4(4'd15, 4'd15, 1'b0, 8'd225);
        for (int i = 0; i < 4; i++) begin
            check("t1_busy_high", longint'(busy4), 1);
            check("t1_done_low", longint'(done4), 0);
            @(negedge clk);
        end
        check("t1_busy_low_at_done", longint'(busy4), 0);
        check("t1_done_high", longint'(done4), 1);
        repeat (3) @(negedge clk);
        check("t1_done_fell", longint'(done4), 0);
        check("t1_out_held", longint'(out4), 225);

        // Back-to-back: second start lands in the done cycle
        issue4(4'd10, 4'd10, 1'b0, 8'd100);
        wait_idle4();
        check("t2_start_in_done_cycle", longint'(done4), 1);
        issue4(4'd9, 4'd8, 1'b0, 8'd72);
        drain(50);

        // start while busy is ignored
        issue4(4'd1, 4'd10, 1'b0, 8'd10);
        @(negedge clk);
        a4 = 4'd3;
        b4 = 4'd3;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        drain(50);
        repeat (10) @(negedge clk);
        check("t3_out_after_ignored", longint'(out4), 10);
        check("t3_idle_after_ignored", longint'(busy4), 0);

        // Asynchronous reset mid-operation
        issue4(4'd9, 4'd8, 1'b0, 8'd72);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_rst_busy", longint'(busy4), 0);
        check("t4_rst_done", longint'(done4), 0);
        check("t4_rst_out",  longint'(out4), 0);
        q4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue4(4'd2, 4'd2, 1'b0, 8'd4);
        drain(50);
        repeat (8) @(negedge clk);
        check("t4_out_after_reset", longint'(out4), 4);

        // Table vectors, issued as fast as the block accepts
        foreach (vecs[i]) issue4(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp);
        drain(200);

        // WIDTH=8 corners
        issue8(8'd255, 8'd255, 16'd65025);
        issue8(8'd0,   8'd200, 16'd0);
        issue8(8'd200, 8'd3,   16'd600);
        issue8(8'd128, 8'd1,   16'd128);
        drain(200);
        repeat (4) @(negedge clk);
        check("w8_out_held", longint'(out8), 128);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
